seq_gen_moore: RTL
==================

# seq_gen_moore

Serial pattern transmitter that drives the input of the 1011 Moore sequence detector. On a start request it emits a fixed PAT_W-bit pattern MSB-first on a one-bit serial line, repeated a programmed number of times, with an optional run of zero bits between repetitions. Control is a registered Moore FSM with a bit index and repetition counter. It pairs with the detector in loopback benches and in the serial test-stimulus path.

## Interface
- PAT_W, 4, pattern length in bits (≥2)
- PATTERN, 4'b1011, transmitted pattern, bit PAT_W-1 sent first
- CNT_W, 4, width of repetition count
- GAP_LEN, 1, zero bits inserted between repetitions (0 = back-to-back)
- clk  input  1  clock, all state updates on posedge
- rst  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE or DONE
- count  input  CNT_W  repetitions; latched when start is accepted
- out  output  1  serial data bit, registered
- valid  output  1  high while out carries a pattern or gap bit
- busy  output  1  high from first transmitted bit through last pattern bit
- done  output  1  one-cycle pulse after the last pattern bit (or after a zero-count start)

## Operation
- States: IDLE, SHIFT, GAP, DONE. Outputs depend only on registered state/counters (Moore); out, valid, busy, done are registers.
- Reset (rst=0, async): state=IDLE, out=0, valid=0, busy=0, done=0, bit index=PAT_W-1, rep counter=0.
- IDLE: outputs 0. start=1 with count≠0 → SHIFT, latch count, bit index=PAT_W-1. start=1 with count=0 → DONE (no bits sent). start=0 → stay.
- SHIFT: out=PATTERN[bit index], valid=1, busy=1. Index decrements each cycle. At index 0: if remaining reps >1 and GAP_LEN>0 → GAP; if remaining >1 and GAP_LEN=0 → SHIFT with index reloaded to PAT_W-1; if last rep → DONE. Rep counter decrements at each pattern end.
- GAP: out=0, valid=1, busy=1 for exactly GAP_LEN cycles, then SHIFT with index=PAT_W-1.
- DONE: done=1, busy=0, valid=0, out=0 for one cycle. start=1 here is accepted exactly as in IDLE (back-to-back jobs); else → IDLE.
- start while in SHIFT/GAP is ignored; count changes outside acceptance are ignored.
- Rep counter width CNT_W; count=2^CNT_W−1 must send that many reps without wrap.

## Timing
- start accepted at edge k → first pattern bit on out in cycle after edge k+1 (latency 1).
- Job of N≥1 reps occupies N·PAT_W + (N−1)·GAP_LEN consecutive busy cycles; done is high the cycle immediately after the last pattern bit; no trailing gap.
- count=0: done high in cycle after edge k+1; busy and valid never assert.
- Default PATTERN/GAP_LEN yield exactly N detector hits for N reps (no false overlaps in 1011 0 1011).
- rst asserted mid-job: outputs go to reset values immediately (asynchronously), job aborted, no done pulse; first start after rst release behaves as from IDLE.

## Structure
- Shared package seq_pkg: state encoding constants (IDLE, SHIFT, GAP, DONE), PATTERN_1011 constant used by both this block and the detector bench.
- Single module; no sub-module needed. Gap counter width $clog2(GAP_LEN+1), minimum 1.

## Test plan
- count=1, start pulse at edge k → out=1,0,1,1 with valid=1 in cycles k+1..k+4; done=1 in cycle k+5; busy low from k+5.
- count=3, GAP_LEN=1, out looped into detector → stream 1011 0 1011 0 1011; detector out pulses exactly 3 times; busy high 14 cycles.
- GAP_LEN=0, count=2 → 10111011 contiguous, done in cycle k+9, detector hits = 2.
- count=0 start → done pulse at k+1, valid/busy stay 0; start held high during a count=2 job → ignored mid-job, new job starts from DONE cycle.
- count=15 → 60 pattern bits + 14 gap bits, done once, no counter wrap.
- rst low at third bit of a job → out/valid/busy/done=0 immediately, no done; restart with count=1 produces clean 1011.

Source files
------------

// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
//   Definitions shared by the serial pattern transmitter and the 1011 sequence
//   detector benches.
//   - state_t      : transmitter FSM states
//   - PATTERN_1011 : default transmitted pattern, MSB sent first
// -----------------------------------------------------------------------------
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int          PATTERN_1011_W = 4;
    localparam logic [3:0]  PATTERN_1011   = 4'b1011;

endpackage

// File: rtl/seq_gen_moore.sv
// -----------------------------------------------------------------------------
// seq_gen_moore
//   Serial pattern transmitter. On an accepted start it sends PATTERN MSB-first
//   on 'out', repeated 'count' times, with GAP_LEN zero bits between
//   repetitions. All outputs are registered decodes of the FSM state held in
//   the previous cycle, so the first bit appears one cycle after acceptance.
//
//   Parameters
//     PAT_W    pattern length in bits (>= 2)
//     PATTERN  transmitted pattern, bit PAT_W-1 first
//     CNT_W    width of the repetition count
//     GAP_LEN  zero bits between repetitions (0 = back-to-back)
//   Ports
//     clk    clock, posedge
//     rst    asynchronous active-low reset
//     start  job request, sampled only in IDLE or DONE
//     count  repetitions, latched when start is accepted
//     out    serial data bit
//     valid  out carries a pattern or gap bit
//     busy   first transmitted bit through last pattern bit
//     done   one-cycle pulse after the last pattern bit / zero-count start
// -----------------------------------------------------------------------------
module seq_gen_moore
    import seq_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = PAT_W'(PATTERN_1011),
    parameter int               CNT_W   = 4,
    parameter int               GAP_LEN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic             out,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam int IW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam int GW = (GAP_LEN > 0) ? $clog2(GAP_LEN + 1) : 1;

    localparam logic [IW-1:0] IDX_TOP  = IW'(PAT_W - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

    state_t           state;
    logic [IW-1:0]    idx;
    logic [CNT_W-1:0] reps;   // repetitions still to send, including current
    logic [GW-1:0]    gcnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            idx   <= IDX_TOP;
            reps  <= '0;
            gcnt  <= '0;
            out   <= 1'b0;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            // Outputs reflect the state of the cycle that is ending now.
            out   <= (state == SHIFT) ? PATTERN[idx] : 1'b0;
            valid <= (state == SHIFT) || (state == GAP);
            busy  <= (state == SHIFT) || (state == GAP);
            done  <= (state == DONE);

            case (state)
                IDLE, DONE: begin
                    // DONE accepts a new job just like IDLE, allowing
                    // back-to-back jobs without an idle cycle.
                    if (start) begin
                        idx   <= IDX_TOP;
                        reps  <= count;
                        gcnt  <= '0;
                        state <= (count == '0) ? DONE : SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end

                SHIFT: begin
                    if (idx == '0) begin
                        reps <= reps - 1'b1;
                        idx  <= IDX_TOP;
                        if (reps > CNT_W'(1))
                            state <= (GAP_LEN > 0) ? GAP : SHIFT;
                        else
                            state <= DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end

                GAP: begin
                    if (gcnt == GAP_LAST) begin
                        gcnt  <= '0;
                        state <= SHIFT;
                    end else begin
                        gcnt <= gcnt + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
